// File: rtl/magia_print_periph.sv
// magia_print_periph: AXI4 write-only slave for the print/EOC window.
//   BASE_ADDR + 0x0 : EXIT  - byte 0 latched as a sticky exit code
//   BASE_ADDR + 0x4 : STDIO - byte 0 pushed with its AXI ID into a character FIFO
//   anything else   : accepted and discarded, answered with SLVERR
// Characters leave on a valid/ready stream once a whole line (or a full FIFO) is buffered.
// Ports:
//   clk, rst_n                      clock, asynchronous active-high reset
//   aw_*, w_*, b_*                  AXI4 write channels (fixed bursts, terminated by w_last)
//   out_valid/out_ready/out_char/out_id/out_eol   character stream from the FIFO head
//   exit_valid, exit_code           sticky end-of-computation flag and last exit code
module magia_print_periph #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR  = 32'hFFFF_0000,
    parameter int unsigned          ID_W       = 2,
    parameter int unsigned          FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [ID_W-1:0]   aw_id,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [31:0]       w_data,
    input  logic [3:0]        w_strb,
    input  logic              w_last,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [ID_W-1:0]   b_id,
    output logic [1:0]        b_resp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic [ID_W-1:0]   out_id,
    output logic              out_eol,
    output logic              exit_valid,
    output logic [7:0]        exit_code
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] EXIT_ADDR  = BASE_ADDR;
    localparam logic [ADDR_W-1:0] STDIO_ADDR = BASE_ADDR + ADDR_W'(4);
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;
    typedef enum logic [1:0] {TgtExit, TgtStdio, TgtOther} tgt_e;

    state_e            state_q, state_d;
    tgt_e              tgt_q, tgt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              err_q, err_d;
    logic              exit_valid_q, exit_valid_d;
    logic [7:0]        exit_code_q, exit_code_d;

    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    nl_cnt_q, nl_cnt_d;
    logic [ID_W+7:0]   mem [FIFO_DEPTH];
    logic [ID_W+7:0]   head;
    logic              fifo_full, fifo_empty;
    logic              push, pop, push_nl, pop_nl;
    logic              aw_ready_int;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign head     = mem[rd_ptr_q[PTR_W-1:0]];
    assign out_char = head[7:0];
    assign out_id   = head[ID_W+7:8];
    assign out_eol  = (head[7:0] == 8'h0A);

    // A full FIFO releases a partial line so STDIO backpressure can always clear.
    assign out_valid = !fifo_empty && ((nl_cnt_q != '0) || fifo_full);
    assign pop       = out_valid && out_ready;
    assign push_nl   = push && (w_data[7:0] == 8'h0A);
    assign pop_nl    = pop && out_eol;

    assign aw_ready   = aw_ready_int && !rst_n;
    assign b_id       = id_q;
    assign exit_valid = exit_valid_q;
    assign exit_code  = exit_code_q;

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        id_d         = id_q;
        err_d        = err_q;
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        aw_ready_int = 1'b0;
        w_ready      = 1'b0;
        b_valid      = 1'b0;
        b_resp       = RESP_OKAY;
        push         = 1'b0;
        unique case (state_q)
            StIdle: begin
                aw_ready_int = 1'b1;
                if (aw_valid) begin
                    id_d = aw_id;
                    if (aw_addr == EXIT_ADDR) begin
                        tgt_d = TgtExit;
                    end else if (aw_addr == STDIO_ADDR) begin
                        tgt_d = TgtStdio;
                    end else begin
                        tgt_d = TgtOther;
                    end
                    state_d = StData;
                end
            end
            StData: begin
                w_ready = !((tgt_q == TgtStdio) && fifo_full);
                if (w_valid && w_ready) begin
                    case (tgt_q)
                        TgtStdio: push = w_strb[0];
                        TgtExit: begin
                            if (w_strb[0]) begin
                                exit_code_d  = w_data[7:0];
                                exit_valid_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                    if (w_last) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                b_valid = 1'b1;
                if (err_q) begin
                    b_resp = RESP_SLVERR;
                end
                if (b_ready) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        nl_cnt_d = nl_cnt_q;
        if (push_nl && !pop_nl) begin
            nl_cnt_d = nl_cnt_q + 1'b1;
        end else if (pop_nl && !push_nl) begin
            nl_cnt_d = nl_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= StIdle;
            tgt_q        <= TgtOther;
            id_q         <= '0;
            err_q        <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= 8'h00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            nl_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            id_q         <= id_d;
            err_q        <= err_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
            nl_cnt_q     <= nl_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= {id_q, w_data[7:0]};
        end
    end

endmodule

// File: tb/tb_magia_print_periph.sv
module tb_magia_print_periph;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] STDIO = 32'hFFFF_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [1:0]  aw_id;
    logic        w_valid, w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [1:0]  b_id, b_resp;
    logic        out_valid, out_ready;
    logic [7:0]  out_char;
    logic [1:0]  out_id;
    logic        out_eol;
    logic        exit_valid;
    logic [7:0]  exit_code;

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_q[$];   // {id, char} in expected stream order

    always #5 clk = ~clk;

    magia_print_periph #(
        .ADDR_W    (32),
        .BASE_ADDR (BASE),
        .ID_W      (2),
        .FIFO_DEPTH(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .aw_addr   (aw_addr),
        .aw_id     (aw_id),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_last    (w_last),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_id      (b_id),
        .b_resp    (b_resp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_id    (out_id),
        .out_eol   (out_eol),
        .exit_valid(exit_valid),
        .exit_code (exit_code)
    );

    // Scoreboard side: every stream handshake is checked against the queue head.
    always @(negedge clk) begin : mon
        logic [9:0] e;
        if (!rst_n && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stream_extra: got char %h id %0d, expected no output",
                         out_char, out_id);
            end else begin
                e = exp_q.pop_front();
                if ({out_id, out_char} !== e || out_eol !== (e[7:0] == 8'h0A)) begin
                    miscompares++;
                    $display("FAIL stream_char: got id %0d char %h eol %b, expected id %0d char %h eol %b",
                             out_id, out_char, out_eol, e[9:8], e[7:0], (e[7:0] == 8'h0A));
                end
            end
        end
    end

    task automatic send_aw(input logic [31:0] addr, input logic [1:0] id, output bit ok);
        bit hs;
        ok = 1'b0;
        aw_addr  = addr;
        aw_id    = id;
        aw_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            hs = aw_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        aw_valid = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL aw_timeout: aw_ready stayed 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic send_w(input logic [7:0] d, input logic [3:0] s, input logic l,
                          input int limit, output bit ok);
        bit hs;
        ok = 1'b0;
        w_data  = {24'h0, d};
        w_strb  = s;
        w_last  = l;
        w_valid = 1'b1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            hs = w_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL w_timeout: w_ready stayed 0, expected 1 within %0d cycles", limit);
        end
    endtask

    task automatic get_b(output logic [1:0] bid, output logic [1:0] bresp, output bit ok);
        bit hs;
        ok    = 1'b0;
        bid   = 'x;
        bresp = 'x;
        b_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            hs    = b_valid;
            bid   = b_id;
            bresp = b_resp;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        b_ready = 1'b0;
        if (!ok) begin
            miscompares++;
            $display("FAIL b_timeout: b_valid stayed 0, expected 1 within 20 cycles");
        end
    endtask

    // Full write transaction; STDIO bytes with strobe 0 set are queued as expected output.
    task automatic axi_write(input logic [31:0] addr, input logic [1:0] id, input int nb,
                             input logic [31:0] bytes, input logic [3:0] strb,
                             output logic [1:0] bid, output logic [1:0] bresp);
        bit ok;
        send_aw(addr, id, ok);
        for (int i = 0; i < nb; i++) begin
            if (addr == STDIO && strb[0]) begin
                exp_q.push_back({id, bytes[8*i+:8]});
            end
            send_w(bytes[8*i+:8], strb, (i == nb - 1), 20, ok);
        end
        get_b(bid, bresp, ok);
    endtask

    task automatic wait_drain(input int limit);
        for (int n = 0; n < limit && exp_q.size() != 0; n++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        aw_valid = 1'b0; aw_addr = '0; aw_id = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
        b_ready = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({aw_ready, w_ready, b_valid, out_valid, exit_valid} !== 5'b0 ||
            b_id !== 2'd0 || b_resp !== 2'd0 || exit_code !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got hs=%b b_id=%0d b_resp=%0d exit_code=%h, expected all 0",
                     {aw_ready, w_ready, b_valid, out_valid, exit_valid}, b_id, b_resp, exit_code);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (aw_ready !== 1'b1 || w_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got aw_ready=%b w_ready=%b, expected 1/0", aw_ready, w_ready);
        end
    endtask

    task automatic test_stdio_line();
        logic [7:0] msg [3];
        logic [1:0] bid, bresp;
        msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            axi_write(STDIO, 2'd1, 1, {24'h0, msg[i]}, 4'hF, bid, bresp);
            vectors++;
            if (bid !== 2'd1 || bresp !== 2'd0) begin
                miscompares++;
                $display("FAIL stdio_b: got b_id=%0d b_resp=%0d, expected 1/0", bid, bresp);
            end
            if (i < 2) begin
                @(negedge clk);
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL partial_hold: got out_valid=%b, expected 0", out_valid);
                end
                @(posedge clk);
                #1;
            end
        end
        wait_drain(50);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stdio_drain: got %0d chars pending, expected 0", exp_q.size());
        end
        // Strobe 0 on STDIO: OKAY and nothing queued (monitor catches a stray char).
        axi_write(STDIO, 2'd1, 1, 32'h51, 4'h0, bid, bresp);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bresp !== 2'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL strb0: got b_resp=%0d out_valid=%b, expected 0/0", bresp, out_valid);
        end
    endtask

    task automatic test_exit();
        bit ok;
        logic [1:0] bid, bresp;
        send_aw(BASE, 2'd0, ok);
        send_w(8'h05, 4'hF, 1'b1, 20, ok);
        vectors++;
        if (b_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b_latency: got b_valid=%b one cycle after w_last, expected 1", b_valid);
        end
        get_b(bid, bresp, ok);
        vectors++;
        if (bresp !== 2'd0 || exit_valid !== 1'b1 || exit_code !== 8'h05) begin
            miscompares++;
            $display("FAIL exit_first: got resp=%0d valid=%b code=%h, expected 0/1/05",
                     bresp, exit_valid, exit_code);
        end
        axi_write(BASE, 2'd0, 1, 32'h00, 4'hF, bid, bresp);
        vectors++;
        if (bresp !== 2'd0 || exit_valid !== 1'b1 || exit_code !== 8'h00) begin
            miscompares++;
            $display("FAIL exit_second: got resp=%0d valid=%b code=%h, expected 0/1/00",
                     bresp, exit_valid, exit_code);
        end
    endtask

    task automatic test_other_burst();
        logic [1:0] bid, bresp;
        axi_write(BASE + 32'd8, 2'd3, 4, 32'h0A77_0A77, 4'hF, bid, bresp);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bid !== 2'd3 || bresp !== 2'd2) begin
            miscompares++;
            $display("FAIL other_b: got b_id=%0d b_resp=%0d, expected 3/2", bid, bresp);
        end
        vectors++;
        if (exit_code !== 8'h00 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL other_side: got exit_code=%h out_valid=%b, expected 00/0",
                     exit_code, out_valid);
        end
        axi_write(BASE, 2'd1, 1, 32'h09, 4'hF, bid, bresp);
        vectors++;
        if (bresp !== 2'd0) begin
            miscompares++;
            $display("FAIL err_cleared: got b_resp=%0d after SLVERR, expected 0", bresp);
        end
    endtask

    task automatic test_full_flush();
        bit ok, stalled;
        logic [1:0] bid, bresp;
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            axi_write(STDIO, 2'd2, 1, 32'h61 + 32'(i % 26), 4'hF, bid, bresp);
            if (i == 62) begin
                @(negedge clk);
                vectors++;
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL almost_full: got out_valid=%b with 63 chars, expected 0", out_valid);
                end
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_flush: got out_valid=%b with 64 chars, expected 1", out_valid);
        end
        @(posedge clk);
        #1;
        send_aw(STDIO, 2'd2, ok);
        w_data = 32'h5A; w_strb = 4'hF; w_last = 1'b1; w_valid = 1'b1;
        exp_q.push_back({2'd2, 8'h5A});
        stalled = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (w_ready !== 1'b0) stalled = 1'b0;
        end
        vectors++;
        if (!stalled) begin
            miscompares++;
            $display("FAIL backpressure: got w_ready=1 with full FIFO, expected 0");
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_w(8'h5A, 4'hF, 1'b1, 20, ok);
        get_b(bid, bresp, ok);
        vectors++;
        if (!ok || bresp !== 2'd0) begin
            miscompares++;
            $display("FAIL full_65th: got ok=%b b_resp=%0d, expected 1/0", ok, bresp);
        end
        // The remaining partial line only drains once a newline closes it.
        axi_write(STDIO, 2'd2, 1, 32'h0A, 4'hF, bid, bresp);
        wait_drain(200);
        vectors++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain: got %0d pending, out_valid=%b, expected 0/0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_interleave();
        logic [1:0] bid, bresp;
        out_ready = 1'b0;
        axi_write(STDIO, 2'd0, 1, 32'h41, 4'hF, bid, bresp);
        axi_write(STDIO, 2'd0, 1, 32'h0A, 4'hF, bid, bresp);
        axi_write(STDIO, 2'd2, 1, 32'h42, 4'hF, bid, bresp);
        axi_write(STDIO, 2'd2, 1, 32'h0A, 4'hF, bid, bresp);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_char !== 8'h41 || out_id !== 2'd0 || out_eol !== 1'b0) begin
            miscompares++;
            $display("FAIL inter_head: got v=%b char=%h id=%0d eol=%b, expected 1/41/0/0",
                     out_valid, out_char, out_id, out_eol);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain(50);
        axi_write(STDIO, 2'd1, 1, 32'h43, 4'hF, bid, bresp);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || exp_q.size() != 1) begin
            miscompares++;
            $display("FAIL nl_cnt_zero: got out_valid=%b pending=%0d, expected 0/1",
                     out_valid, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        bit ok, saw_b;
        logic [1:0] bid, bresp;
        out_ready = 1'b0;
        send_aw(STDIO, 2'd1, ok);
        send_w(8'h78, 4'hF, 1'b0, 20, ok);
        send_w(8'h79, 4'hF, 1'b0, 20, ok);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        vectors++;
        if (b_valid !== 1'b0 || out_valid !== 1'b0 || exit_valid !== 1'b0 || exit_code !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: got b_valid=%b out_valid=%b exit_valid=%b code=%h, expected 0/0/0/00",
                     b_valid, out_valid, exit_valid, exit_code);
        end
        rst_n = 1'b0;
        saw_b = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (b_valid) saw_b = 1'b1;
        end
        vectors++;
        if (saw_b) begin
            miscompares++;
            $display("FAIL aborted_b: got b_valid=1 after reset, expected 0");
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        axi_write(STDIO, 2'd3, 1, 32'h0A, 4'hF, bid, bresp);
        wait_drain(50);
        vectors++;
        if (bid !== 2'd3 || bresp !== 2'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset: got b_id=%0d b_resp=%0d pending=%0d, expected 3/0/0",
                     bid, bresp, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stdio_line();
        test_exit();
        test_other_burst();
        test_full_flush();
        test_interleave();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
